// File: rtl/weight_loader.sv
// Streams a flattened weight image, DW bits per word, into the model's serial weight chain.
// Bits leave LSB-first, one per cycle; exactly WEIGHTS_B shifts are issued per load.
module weight_loader #(
  parameter int unsigned WEIGHTS_B = 12864,
  parameter int unsigned DW        = 32,
  parameter int unsigned CB        = $clog2(WEIGHTS_B + 1)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  output logic          copy,
  output logic          k,
  output logic          busy,
  output logic          done
);

  localparam int unsigned WW = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [WW-1:0] WLast = WW'(DW - 1);
  localparam logic [CB-1:0] BLast = CB'(WEIGHTS_B - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] sreg_q, sreg_d;
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic [CB-1:0] bcnt_q, bcnt_d;
  logic          last_w, last_b;

  assign last_w = (wcnt_q == WLast);
  assign last_b = (bcnt_q == BLast);

  // Ready depends on state and counters only, never on s_valid.
  always_comb begin
    s_ready = 1'b0;
    unique case (state_q)
      StLoad:  s_ready = 1'b1;
      StShift: s_ready = last_w && !last_b;
      default: s_ready = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    wcnt_d  = wcnt_q;
    bcnt_d  = bcnt_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StLoad;
          wcnt_d  = '0;
          bcnt_d  = '0;
        end
      end
      StLoad: begin
        if (s_valid) begin
          sreg_d  = s_data;
          wcnt_d  = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        sreg_d = sreg_q >> 1;
        wcnt_d = wcnt_q + WW'(1);
        bcnt_d = bcnt_q + CB'(1);
        // Final image bit wins over a word boundary; leftover word bits are dropped.
        if (last_b) begin
          state_d = StDone;
        end else if (last_w) begin
          if (s_valid) begin
            sreg_d = s_data;
            wcnt_d = '0;
          end else begin
            state_d = StLoad;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      sreg_q  <= '0;
      wcnt_q  <= '0;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      wcnt_q  <= wcnt_d;
      bcnt_q  <= bcnt_d;
    end
  end

  assign copy = (state_q == StShift);
  assign k    = sreg_q[0];
  assign busy = (state_q == StLoad) || (state_q == StShift);
  assign done = (state_q == StDone);

endmodule

// File: tb/tb_weight_loader.sv
// Bench for weight_loader: a default-size instance for full/abort/restart loads and a
// 40-bit/16-bit instance driven from a vector table for partial-word, stall and timing cases.
module tb_weight_loader;

  localparam int unsigned BW  = 12864;
  localparam int unsigned BDW = 32;
  localparam int unsigned NWB = 402;
  localparam int unsigned SW  = 40;
  localparam int unsigned SDW = 16;

  logic clk = 1'b0;
  logic rstn = 1'b0;

  logic           b_start = 1'b0, b_valid = 1'b0;
  logic [BDW-1:0] b_data = '0;
  logic           b_ready, b_copy, b_k, b_busy, b_done;

  logic           m_start = 1'b0, m_valid = 1'b0;
  logic [SDW-1:0] m_data = '0;
  logic           m_ready, m_copy, m_k, m_busy, m_done;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  weight_loader u_big (
    .clk(clk), .rstn(rstn), .start(b_start), .s_valid(b_valid), .s_ready(b_ready),
    .s_data(b_data), .copy(b_copy), .k(b_k), .busy(b_busy), .done(b_done)
  );

  weight_loader #(.WEIGHTS_B(SW), .DW(SDW)) u_small (
    .clk(clk), .rstn(rstn), .start(m_start), .s_valid(m_valid), .s_ready(m_ready),
    .s_data(m_data), .copy(m_copy), .k(m_k), .busy(m_busy), .done(m_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboards: word bits are queued at each handshake and popped on each copy cycle.
  bit          bq[$];
  logic [BW-1:0] b_img = '0;
  logic [BDW-1:0] b_words[NWB];
  int b_hs = 0, b_ncopy = 0, b_first = -1, b_last = -1, b_done_at = -1, b_kerr = 0;
  int b_start_cyc = 0;

  always @(negedge clk) begin
    if (b_start && !b_busy) begin
      bq.delete();
      b_hs = 0; b_ncopy = 0; b_first = -1; b_last = -1; b_done_at = -1; b_kerr = 0;
      b_start_cyc = cyc;
    end else begin
      if (b_valid && b_ready) begin
        b_hs++;
        for (int i = 0; i < BDW; i++) bq.push_back(b_data[i]);
      end
      if (b_copy) begin
        if (bq.size() == 0 || bq.pop_front() != b_k) b_kerr++;
        b_img = {b_k, b_img[BW-1:1]};
        b_ncopy++;
        if (b_first < 0) b_first = cyc - b_start_cyc;
        b_last = cyc - b_start_cyc;
      end
      if (b_done && b_done_at < 0) b_done_at = cyc - b_start_cyc;
    end
  end

  bit          mq[$];
  logic [SW-1:0] m_img = '0;
  int m_hs = 0, m_ncopy = 0, m_first = -1, m_last = -1, m_done_at = -1, m_kerr = 0;
  int m_gap = 0, m_start_cyc = 0;

  always @(negedge clk) begin
    if (m_start && !m_busy) begin
      mq.delete();
      m_hs = 0; m_ncopy = 0; m_first = -1; m_last = -1; m_done_at = -1; m_kerr = 0;
      m_gap = 0; m_start_cyc = cyc;
    end else begin
      if (m_valid && m_ready) begin
        m_hs++;
        for (int i = 0; i < SDW; i++) mq.push_back(m_data[i]);
      end
      if (m_copy) begin
        if (mq.size() == 0 || mq.pop_front() != m_k) m_kerr++;
        m_img = {m_k, m_img[SW-1:1]};
        m_ncopy++;
        if (m_first < 0) m_first = cyc - m_start_cyc;
        m_last = cyc - m_start_cyc;
      end
      if (m_busy && !m_copy && m_first >= 0) m_gap++;
      if (m_done && m_done_at < 0) m_done_at = cyc - m_start_cyc;
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0][15:0] w;
    int               stall;
    bit               mid;
    logic [39:0]      img;
    int               done_at;
  } vec_t;

  vec_t tbl[4];

  task automatic run_small(input vec_t v);
    int i, st, n;
    @(posedge clk); #1 m_start = 1'b1;
    @(posedge clk); #1 m_start = 1'b0;
    i = 0; st = 0; n = 0;
    while (i < 3 && n < 200) begin
      m_data  = v.w[i];
      m_valid = !(i == 2 && st < v.stall);
      m_start = v.mid && (n == 8);
      @(negedge clk);
      if (m_ready) begin
        if (m_valid) i++;
        else st++;
      end
      @(posedge clk); #1 n++;
    end
    m_start = 1'b0;
    // Surplus word offered; it must never be taken.
    m_data  = 16'hDEAD;
    m_valid = 1'b1;
    n = 0;
    while (!m_done && n < 200) begin
      @(posedge clk); #1 n++;
    end
    repeat (3) @(posedge clk);
    #1 m_valid = 1'b0;
    @(negedge clk);
    chk("small_handshakes", m_hs, 3);
    chk("small_shifts", m_ncopy, SW);
    chk("small_first_copy", m_first, 2);
    chk("small_last_copy", m_last, v.done_at - 1);
    chk("small_done_cycle", m_done_at, v.done_at);
    chk("small_stall_gap", m_gap, v.stall);
    chk("small_k_stream", m_kerr, 0);
    chk("small_image", m_img, v.img);
    chk("small_done_level", {m_done, m_busy}, 2'b10);
  endtask

  task automatic run_big(input int abort_at);
    int i, n, nbw;
    for (int j = 0; j < NWB; j++) b_words[j] = $urandom;
    @(posedge clk); #1 b_start = 1'b1;
    @(posedge clk); #1 b_start = 1'b0;
    i = 0; n = 0;
    while (i < NWB && n < 20000) begin
      b_data  = b_words[i];
      b_valid = 1'b1;
      @(negedge clk);
      if (n == 0) chk("big_load_at_1", {b_busy, b_done, b_ready}, 3'b101);
      if (b_ready) i++;
      if (abort_at > 0 && b_ncopy >= abort_at) begin
        #2 rstn = 1'b0;
        #1 chk("abort_async_idle", {b_copy, b_busy, b_done, b_ready}, 4'b0000);
        @(posedge clk); #1 rstn = 1'b1;
        b_valid = 1'b0;
        return;
      end
      @(posedge clk); #1 n++;
    end
    b_data  = 32'hBAD0_BAD0;
    b_valid = 1'b1;
    n = 0;
    while (!b_done && n < 100) begin
      @(posedge clk); #1 n++;
    end
    repeat (3) @(posedge clk);
    #1 b_valid = 1'b0;
    @(negedge clk);
    nbw = 0;
    for (int j = 0; j < NWB; j++) if (b_img[j*BDW +: BDW] != b_words[j]) nbw++;
    chk("big_handshakes", b_hs, NWB);
    chk("big_shifts", b_ncopy, BW);
    chk("big_first_copy", b_first, 2);
    chk("big_last_copy", b_last, BW + 1);
    chk("big_done_cycle", b_done_at, BW + 2);
    chk("big_k_stream", b_kerr, 0);
    chk("big_image_bad_words", nbw, 0);
    chk("big_done_level", {b_done, b_busy}, 2'b10);
  endtask

  initial begin
    int nz;
    tbl[0] = '{w: {16'hFF12, 16'h0FF0, 16'hA5C3}, stall: 0, mid: 1'b0,
               img: 40'h12_0FF0_A5C3, done_at: 42};
    tbl[1] = '{w: {16'hABCD, 16'h0000, 16'hFFFF}, stall: 5, mid: 1'b0,
               img: 40'hCD_0000_FFFF, done_at: 47};
    tbl[2] = '{w: {16'h9ABC, 16'h5678, 16'h1234}, stall: 0, mid: 1'b1,
               img: 40'hBC_5678_1234, done_at: 42};
    tbl[3] = '{w: {16'h00C5, 16'h7FFE, 16'h8001}, stall: 2, mid: 1'b0,
               img: 40'hC5_7FFE_8001, done_at: 44};

    // Reset and idle with a source that is always valid.
    b_valid = 1'b1; b_data = '1;
    m_valid = 1'b1; m_data = '1;
    repeat (3) @(negedge clk);
    chk("rst_ready", b_ready, 0);
    chk("rst_copy", b_copy, 0);
    chk("rst_k", b_k, 0);
    chk("rst_busy", b_busy, 0);
    chk("rst_done", b_done, 0);
    chk("rst_small_outputs", {m_ready, m_copy, m_k, m_busy, m_done}, 0);
    @(posedge clk); #1 rstn = 1'b1;
    nz = 0;
    repeat (10) begin
      @(negedge clk);
      nz += int'(b_ready | b_copy | b_k | b_busy | b_done | m_ready | m_copy | m_k | m_busy |
                 m_done);
    end
    chk("idle_outputs", nz, 0);
    chk("idle_no_accept", b_hs + m_hs, 0);
    @(posedge clk); #1 b_valid = 1'b0; m_valid = 1'b0;

    for (int t = 0; t < 4; t++) run_small(tbl[t]);

    run_big(0);
    run_big(100);
    repeat (3) @(negedge clk);
    chk("post_abort_idle", {b_copy, b_busy, b_done, b_ready}, 4'b0000);
    run_big(0);
    run_big(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/weight_loader.md
# weight_loader

Upstream feeder for the quantized model's serial weight chain. It accepts the flattened weight image as DW-bit words over a valid/ready stream and shifts it out one bit per cycle onto the model's `k`/`copy` inputs. After exactly WEIGHTS_B shifts, bit i of the weight image sits in bit i of the model's weight register. The stream supplies bits LSB-first, and word 0 carries image bits [DW-1:0].

## Interface
- `WEIGHTS_B`, 12864: total weight bits; the length of the model's shift chain.
- `DW`, 32: input word width; 1 ≤ DW ≤ WEIGHTS_B.
- `CB`, $clog2(WEIGHTS_B+1): width of the bit counter (derived).
- `clk`  in  1  single clock; all logic rises on posedge.
- `rstn`  in  1  asynchronous, active-low reset.
- `start`  in  1  begins a load; sampled only in IDLE or DONE.
- `s_valid`  in  1  input word valid.
- `s_ready`  out  1  input word accepted when `s_valid && s_ready`.
- `s_data`  in  DW  input word; bit 0 is shifted first.
- `copy`  out  1  shift enable to the model's weight register.
- `k`  out  1  serial weight bit to the model.
- `busy`  out  1  high in LOAD or SHIFT.
- `done`  out  1  high in DONE; level, not pulse.

## Operation
- States: IDLE, LOAD, SHIFT, DONE. Reset enters IDLE.
- Registers: `sreg[DW-1:0]` (word shift register), `wcnt` (bit index within the word, 0..DW-1), `bcnt[CB-1:0]` (bits sent, 0..WEIGHTS_B-1).
- `copy` is 1 exactly in SHIFT.
- `k` = `sreg[0]`.
- `busy` = (LOAD or SHIFT).
- `done` = DONE.
- IDLE: `start`=1 → LOAD; clear `bcnt` and `wcnt`.
- LOAD: `s_ready`=1. On handshake: `sreg` ← `s_data`, `wcnt` ← 0, → SHIFT. Without `s_valid`, stay in LOAD; no bits are lost.
- SHIFT: each cycle, `sreg` ← `sreg`>>1, `wcnt`++, `bcnt`++. Two events mark the end of the current bit:
  - last_w = (`wcnt`==DW-1)
  - last_b = (`bcnt`==WEIGHTS_B-1)
- `s_ready` in SHIFT = last_w && !last_b. This lets the next word load with no bubble.
- Exits from SHIFT, in priority order:
  - last_b → DONE. This takes priority and makes the final word partial: its unsent upper bits are discarded.
  - last_w && handshake → stay in SHIFT; `sreg` ← `s_data`, `wcnt` ← 0.
  - last_w && !`s_valid` → LOAD.
- DONE: hold. `start`=1 → LOAD, with counters cleared for a full reload.
- `start` in LOAD or SHIFT is ignored.
- `s_valid` while `s_ready`=0 is not consumed. The source must hold its word.
- Words accepted per load = ceil(WEIGHTS_B/DW). Any extra words are never accepted: `s_ready`=0 in DONE and IDLE.
- Reset mid-load: the block returns to IDLE immediately with `copy`=0. The model's weight register then holds a partial shift, and the only recovery is a new `start`.

## Timing
- Reset values:
  - state=IDLE
  - `s_ready`=0, `copy`=0, `k`=0, `busy`=0, `done`=0
  - `sreg`=0, `wcnt`=0, `bcnt`=0
- `copy` and `k` come straight from flops, with no combinational path from inputs.
- `s_ready` is decoded from state and counters only. It must not depend on `s_valid`.
- Latency from `start` to LOAD is 1 cycle.
- From a handshake in LOAD, the first `copy`=1 is the next cycle.
- With `s_valid` held high, `copy` stays high for exactly WEIGHTS_B consecutive cycles.
- With an always-valid source and `start` at cycle 0:
  - LOAD at cycle 1
  - SHIFT for cycles 2..WEIGHTS_B+1
  - DONE from cycle WEIGHTS_B+2
- Each cycle a source stall lasts in LOAD inserts exactly one cycle with `copy`=0.
- Throughput is 1 bit/cycle, i.e. DW cycles per word, when the source never stalls.

## Test plan
- Reset and idle: hold `rstn`=0, then release and idle for 10 cycles → all outputs 0, `s_ready`=0, and `s_valid`=1 is never accepted.
- Full load with defaults (WEIGHTS_B=12864, DW=32), pseudo-random words, source always valid, `start` at cycle 0:
  - exactly 402 handshakes, and `copy` high for cycles 2..12865
  - `done` rises at cycle 12866
  - a behavioural `{k,q[W-1:1]}` shift model equals the concatenated words
- Partial final word (WEIGHTS_B=40, DW=16), words 0xA5C3, 0x0FF0, 0xFF12:
  - 3 handshakes and 40 shifts
  - model register = 0x12_0FF0_A5C3; the upper byte 0xFF is never shifted
- Backpressure: `s_valid` low for 5 cycles before word 2 → `copy` drops for exactly 5 cycles, `busy` stays 1, and the final image is still bit-exact.
- Reset at bit 100 of a load, then `start` again → `copy`=0 asynchronously and state is IDLE. The reload completes and the final image is correct with no stale bits.
- Restart from DONE:
  - `start` asserted in DONE → LOAD next cycle, `done`=0, second full image loaded correctly
  - `start` asserted in SHIFT → ignored, with no change in counters
